// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP word, fetch FSM state type, PC width.
// The HALT state exists only when IF_ALIGN_TRAP_EN is defined.
package cpu_pkg;

    localparam int PC_W = 32;

    localparam logic [6:0] OP_LW  = 7'b0001101;
    localparam logic [6:0] OP_SW  = 7'b0001110;
    localparam logic [6:0] OP_BEQ = 7'b0001111;
    localparam logic [6:0] OP_BNE = 7'b0010000;
    localparam logic [6:0] OP_BGE = 7'b0010001;
    localparam logic [6:0] OP_BLT = 7'b0010010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

`ifdef IF_ALIGN_TRAP_EN
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1
    } fetch_state_t;
`endif

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: requests one word, holds it for the control unit, then
// advances sequentially or to a branch target. Option macro: IF_ALIGN_TRAP_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     word,
    output logic            word_valid,
    output logic [PC_W-1:0] pc_out,
`ifdef IF_ALIGN_TRAP_EN
    output logic            trap,
`endif
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [PC_W-1:0] branch_target
);

    fetch_state_t    state;
    fetch_state_t    state_d;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_d;
    logic            capture;
    logic            req_en;
`ifdef IF_ALIGN_TRAP_EN
    logic            trap_set;
`endif

    // Requests start on the first edge after reset so none is seen in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_en <= 1'b0;
        else        req_en <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_d;
    end

    // Next state, PC update and capture strobe.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        capture = 1'b0;
`ifdef IF_ALIGN_TRAP_EN
        trap_set = 1'b0;
`endif
        unique case (state)
            FETCH: begin
                if (imem_req && imem_ready) begin
                    capture = 1'b1;
                    pc_d    = pc + PC_W'(4);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    state_d = FETCH;
                    if (pc_sel) begin
`ifdef IF_ALIGN_TRAP_EN
                        if (branch_target[1:0] != 2'b00) begin
                            trap_set = 1'b1;
                            state_d  = HALT;
                        end else begin
                            pc_d = branch_target;
                        end
`else
                        pc_d = branch_target & ~PC_W'(3);
`endif
                    end
                end
            end
`ifdef IF_ALIGN_TRAP_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // PC and held instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            pc_out <= '0;
            word   <= NOP_WORD;
        end else begin
            pc <= pc_d;
            if (capture) begin
                pc_out <= pc;
                word   <= imem_rdata;
            end
        end
    end

`ifdef IF_ALIGN_TRAP_EN
    // Sticky misaligned-target trap, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        trap <= 1'b0;
        else if (trap_set) trap <= 1'b1;
    end
`endif

    // Outputs decoded from state.
    always_comb begin
        imem_req   = req_en && (state == FETCH);
        imem_addr  = pc;
        word_valid = (state == ISSUE);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random
// fetch/stall/branch traffic against a transaction-level PC model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] word;
    logic        word_valid;
    logic [31:0] pc_out;
    logic        stall;
    logic        pc_sel;
    logic [31:0] branch_target;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mpc;
    logic [31:0] mword;
    logic [31:0] mpc_out;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .word          (word),
        .word_valid    (word_valid),
        .pc_out        (pc_out),
        .stall         (stall),
        .pc_sel        (pc_sel),
        .branch_target (branch_target)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch at the model PC: wait dly cycles, then return data d.
    task automatic fetch_one(input int dly, input logic [31:0] d);
        for (int i = 0; i < dly; i++) begin
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, mpc);
            chk("wait_valid", 32'(word_valid), 32'd0);
            imem_ready = 1'b0;
            stall = 1'($urandom);
            step();
        end
        chk("req", 32'(imem_req), 32'd1);
        chk("addr", imem_addr, mpc);
        imem_ready = 1'b1;
        imem_rdata = d;
        stall = 1'($urandom);
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        mword = d;
        mpc_out = mpc;
        mpc = mpc + 32'd4;
        chk("issue_valid", 32'(word_valid), 32'd1);
        chk("issue_req", 32'(imem_req), 32'd0);
        chk("issue_word", word, mword);
        chk("issue_pc", pc_out, mpc_out);
    endtask

    // Hold ISSUE for n stalled cycles, then release with the branch decision.
    task automatic issue(input int n, input logic sel, input logic [31:0] tgt);
        for (int i = 0; i < n; i++) begin
            stall = 1'b1;
            pc_sel = 1'($urandom);
            branch_target = $urandom;
            imem_ready = 1'($urandom);
            step();
            chk("stall_valid", 32'(word_valid), 32'd1);
            chk("stall_word", word, mword);
            chk("stall_pc", pc_out, mpc_out);
        end
        imem_ready = 1'b0;
        stall = 1'b0;
        pc_sel = sel;
        branch_target = tgt;
        step();
        pc_sel = 1'b0;
        if (sel) mpc = {tgt[31:2], 2'b00};
        chk("rel_valid", 32'(word_valid), 32'd0);
        chk("rel_word", word, mword);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        stall = 1'b0;
        pc_sel = 1'b0;
        branch_target = 32'h0;
        mpc = 32'h0;
        mword = 32'h0;
        mpc_out = 32'h0;

        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_word", word, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);

        // Ready already high at release: must not complete before first req.
        imem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Ready tied high: 0,4,8 with alternating valid.
        fetch_one(0, 32'hA000_0000);
        issue(0, 1'b0, 32'h0);
        fetch_one(0, 32'hA000_0004);
        issue(0, 1'b0, 32'h0);
        fetch_one(0, 32'hA000_0008);
        issue(0, 1'b1, 32'h0000_0010);

        // Slow memory at 0x10.
        chk("slow_addr", imem_addr, 32'h10);
        fetch_one(3, 32'hB000_0010);
        issue(0, 1'b1, 32'h0000_0020);

        // Stall at 0x20 with pc_sel toggling.
        fetch_one(1, 32'hC000_0020);
        issue(4, 1'b0, 32'h0);
        chk("after_stall", imem_addr, 32'h24);
        fetch_one(0, 32'hC000_0024);
        issue(0, 1'b1, 32'h0000_0040);

        // Taken branch at 0x40.
        fetch_one(2, 32'hD000_0040);
        issue(1, 1'b1, 32'h0000_0100);
        chk("br_addr", imem_addr, 32'h100);

        // Wraparound.
        fetch_one(0, 32'hE000_0100);
        issue(0, 1'b1, 32'hFFFF_FFFC);
        fetch_one(1, 32'hE000_FFFC);
        issue(0, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned target is aligned down.
        fetch_one(0, 32'hF000_0000);
        issue(0, 1'b1, 32'h0000_0102);
        chk("mis_addr", imem_addr, 32'h100);

        // Reset mid-request abandons it.
        fetch_one(0, 32'h1111_1111);
        issue(0, 1'b1, 32'h0000_0200);
        @(negedge clk);
        rst_n = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_valid", 32'(word_valid), 32'd0);
        chk("mid_rst_word", word, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        step();
        imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mpc = 32'h0;
        chk("rerun_addr", imem_addr, 32'h0);

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] t;
            t = $urandom;
            fetch_one(int'($urandom_range(0, 3)), $urandom);
            issue(int'($urandom_range(0, 2)), 1'($urandom), t);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 imem_req  out  1  instruction-memory read request.
REQ-006 imem_addr  out  32  byte address of the requested word.
REQ-007 imem_ready  in  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 word  out  32  held instruction for the control unit.
REQ-010 word_valid  out  1  word and pc_out are valid this cycle.
REQ-011 pc_out  out  32  address of the held word.
REQ-012 stall  in  1  downstream not ready; hold the current word.
REQ-013 pc_sel  in  1  branch-taken decision from the control unit, valid while word_valid=1.
REQ-014 branch_target  in  32  next PC when pc_sel=1.
REQ-015 trap  out  1  misaligned-target trap; present only with IF_ALIGN_TRAP_EN.

Function
REQ-016 The FSM SHALL have states FETCH, ISSUE and HALT (HALT only with IF_ALIGN_TRAP_EN).
- FETCH: imem_req=1, imem_addr=pc, word_valid=0.
- ISSUE: imem_req=0, word_valid=1.
REQ-017 In FETCH, the block SHALL hold imem_req and imem_addr stable until a cycle with imem_ready=1.
REQ-018 On that imem_ready cycle the block SHALL capture word<=imem_rdata, pc_out<=pc and pc<=pc+4, then go to ISSUE.
REQ-019 Latency from the imem_ready edge to word_valid=1 SHALL be one cycle; throughput SHALL be at most one instruction per two cycles.
REQ-020 In ISSUE with stall=1, the block SHALL hold word, pc_out, pc and the state unchanged, and SHALL ignore pc_sel.
REQ-021 In ISSUE with stall=0 and pc_sel=0, the next state SHALL be FETCH with pc unchanged (sequential).
REQ-022 In ISSUE with stall=0 and pc_sel=1, the block SHALL load pc<=branch_target and go to FETCH, so no instruction after the branch is issued.
REQ-023 stall SHALL be ignored in FETCH; an outstanding request always completes.
REQ-024 PC arithmetic SHALL be 32-bit modulo 2^32: pc=32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-025 In ISSUE, word SHALL change only on the FETCH-to-ISSUE transition.

Reset
REQ-026 When rst_n=0, the block SHALL force, asynchronously: pc=RESET_PC, state=FETCH, word=32'h0000_0000, pc_out=0, word_valid=0, imem_req=0, trap=0.
REQ-027 On deassertion of rst_n, the first request SHALL issue on the next clock edge: imem_req=1, imem_addr=RESET_PC.
REQ-028 Reset mid-request SHALL abandon the request; a late imem_ready after reset SHALL be ignored unless the block is in FETCH.

Configuration
REQ-029 Macro IF_ALIGN_TRAP_EN, when defined: if a taken branch has branch_target[1:0]!=0, the block SHALL set trap=1 and enter HALT.
- trap is sticky.
- In HALT, imem_req=0 and word_valid=0 until reset.
REQ-030 When IF_ALIGN_TRAP_EN is undefined: no trap port and no HALT state; the block SHALL load pc with {branch_target[31:2],2'b00}.

Structure
REQ-031 Shared package cpu_pkg SHALL hold:
- opcode constants: OP_LW=7'b0001101, OP_SW=7'b0001110, OP_BEQ=7'b0001111, OP_BNE=7'b0010000, OP_BGE=7'b0010001, OP_BLT=7'b0010010;
- NOP_WORD=32'h0;
- the fetch FSM state type;
- the PC width constant.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Reset release, RESET_PC=0, imem_ready tied 1 -> imem_addr sequence 0,4,8; word_valid alternates 0/1 every cycle.
REQ-034 imem_ready delayed 3 cycles -> imem_req=1 and imem_addr=0x10 held stable 3 cycles; word_valid=1 exactly one cycle after ready.
REQ-035 ISSUE at pc_out=0x20, stall=1 for 4 cycles with pc_sel toggling -> word and pc_out frozen; next fetch address 0x24.
REQ-036 ISSUE at pc_out=0x40, pc_sel=1, branch_target=0x100 -> next imem_addr=0x100; 0x44 is never requested.
REQ-037 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0.
REQ-038 branch_target=0x102, taken -> with IF_ALIGN_TRAP_EN: trap=1 and imem_req stays 0; without it: next imem_addr=0x100.
